// File: rtl/pulse_fast2slow_tx.sv
// Fast-domain transmit side of a four-phase req/ack pulse handshake.
// An accepted din pulse raises req until ack returns or the timeout expires, then waits for ack to fall.
module pulse_fast2slow_tx #(
    parameter int unsigned STRETCH_MIN = 4,
    parameter int unsigned TIMEOUT     = 0
) (
    input  logic       clk_fast,
    input  logic       rst,
    input  logic       din,
    input  logic       ack_async,
    output logic       req,
    output logic       busy,
    output logic       done,
    output logic       timeout,
    output logic       drop,
    output logic [7:0] drop_cnt
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        REQ      = 2'd1,
        WAIT_LOW = 2'd2
    } state_t;

    localparam logic [15:0] STRETCH_LAST = 16'(STRETCH_MIN - 1);
    localparam bit          TIMEOUT_EN   = (TIMEOUT != 0);
    localparam logic [15:0] TIMEOUT_LAST = TIMEOUT_EN ? 16'(TIMEOUT - 1) : 16'd0;

    (* ASYNC_REG = "TRUE" *) logic ack_s1;
    (* ASYNC_REG = "TRUE" *) logic ack_s2;

    state_t      state_r;
    state_t      next_state_s;
    logic [15:0] cnt_r;
    logic        timeout_hit_s;
    logic        done_hit_s;
    logic        drop_hit_s;

    // Two-flop synchronizer for the acknowledge level from the slow domain.
    always_ff @(posedge clk_fast or posedge rst) begin
        if (rst) begin
            ack_s1 <= 1'b0;
            ack_s2 <= 1'b0;
        end else begin
            ack_s1 <= ack_async;
            ack_s2 <= ack_s1;
        end
    end

    // Next-state decode; a returned ack takes priority over an expiring timeout.
    always_comb begin
        next_state_s  = state_r;
        timeout_hit_s = 1'b0;
        done_hit_s    = 1'b0;
        drop_hit_s    = 1'b0;
        case (state_r)
            IDLE: begin
                if (din) begin
                    next_state_s = REQ;
                end else begin
                    next_state_s = IDLE;
                end
            end
            REQ: begin
                if (ack_s2 && (cnt_r >= STRETCH_LAST)) begin
                    next_state_s = WAIT_LOW;
                end else if (TIMEOUT_EN && !ack_s2 && (cnt_r == TIMEOUT_LAST)) begin
                    next_state_s  = WAIT_LOW;
                    timeout_hit_s = 1'b1;
                end else begin
                    next_state_s = REQ;
                end
            end
            WAIT_LOW: begin
                if (!ack_s2) begin
                    next_state_s = IDLE;
                    done_hit_s   = 1'b1;
                end else begin
                    next_state_s = WAIT_LOW;
                end
            end
            default: begin
                next_state_s = IDLE;
            end
        endcase
        if (din && (state_r != IDLE)) begin
            drop_hit_s = 1'b1;
        end else begin
            drop_hit_s = 1'b0;
        end
    end

    // State register and stretch/timeout cycle counter (cleared while idle so REQ starts at zero).
    always_ff @(posedge clk_fast or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
            cnt_r   <= 16'd0;
        end else begin
            state_r <= next_state_s;
            if (state_r == IDLE) begin
                cnt_r <= 16'd0;
            end else if ((state_r == REQ) && (cnt_r != 16'hFFFF)) begin
                cnt_r <= cnt_r + 16'd1;
            end else begin
                cnt_r <= cnt_r;
            end
        end
    end

    // Registered status outputs, all derived from the decoded next state.
    always_ff @(posedge clk_fast or posedge rst) begin
        if (rst) begin
            req      <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            timeout  <= 1'b0;
            drop     <= 1'b0;
            drop_cnt <= 8'd0;
        end else begin
            req     <= (next_state_s == REQ);
            busy    <= (next_state_s != IDLE);
            done    <= done_hit_s;
            timeout <= timeout_hit_s;
            drop    <= drop_hit_s;
            if (drop_hit_s && (drop_cnt != 8'hFF)) begin
                drop_cnt <= drop_cnt + 8'd1;
            end else begin
                drop_cnt <= drop_cnt;
            end
        end
    end

endmodule
